// File: rtl/seq_div_64by32.sv
// seq_div_64by32: iterative restoring divider, 2W-bit dividend by W-bit divisor, one quotient bit per clock
module seq_div_64by32 #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           ovf
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  r, q, d;
    logic [CW-1:0] cnt;
    logic [W:0]    t;
    logic          ge, accept, ovf_chk, last;
    logic [W-1:0]  r_nxt;

    // One restoring step: the W+1-bit trial value keeps the compare exact for divisors >= 2^(W-1)
    always_comb begin
        t       = {r, q[W-1]};
        ge      = t >= {1'b0, d};
        r_nxt   = ge ? W'(t - {1'b0, d}) : t[W-1:0];
        accept  = (state == IDLE) && in_valid;
        ovf_chk = (divisor == '0) || (dividend[2*W-1:W] >= divisor);
        last    = cnt == CW'(W - 1);
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: overflow short-circuits straight to DONE, otherwise W CALC cycles
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = in_valid ? (ovf_chk ? DONE : CALC) : IDLE;
            CALC:    state_nxt = last ? DONE : CALC;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, shift/subtract in CALC, publish result on the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r         <= '0;
            q         <= '0;
            d         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
        end else if (accept) begin
            if (ovf_chk) begin
                quotient  <= '1;
                remainder <= '0;
                ovf       <= 1'b1;
            end else begin
                r   <= dividend[2*W-1:W];
                q   <= dividend[W-1:0];
                d   <= divisor;
                cnt <= '0;
                ovf <= 1'b0;
            end
        end else if (state == CALC) begin
            r   <= r_nxt;
            q   <= {q[W-2:0], ge};
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
                quotient  <= {q[W-2:0], ge};
                remainder <= r_nxt;
            end
        end
    end
endmodule

// File: tb/tb_seq_div_64by32.sv
// tb_seq_div_64by32: randomized self-checking bench against an arithmetic reference model
module tb_seq_div_64by32;
    localparam int W = 32;

    logic           clk = 0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           ovf;

    int n_chk = 0;
    int n_fail = 0;

    seq_div_64by32 #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit division with the overflow rule applied first
    task automatic model(input logic [63:0] n, input logic [31:0] dv,
                         output logic [31:0] eq, output logic [31:0] er, output logic eo);
        logic [63:0] dd;
        dd = {32'b0, dv};
        eo = (dv == 0) || ((n >> 32) >= dd);
        eq = eo ? 32'hFFFF_FFFF : 32'(n / dd);
        er = eo ? 32'h0 : 32'(n % dd);
    endtask

    // Issue one operation, wait for the result, hold it for `hold` cycles, then retire it
    task automatic run(input logic [63:0] n, input logic [31:0] dv, input int hold, input bit early_ready);
        logic [31:0] eq, er;
        logic eo;
        int g, lat;
        model(n, dv, eq, er, eo);
        dividend = n;
        divisor  = dv;
        in_valid = 1;
        g = 0;
        while (!in_ready && g < 200) begin
            @(posedge clk); #1; g++;
        end
        chk("accept_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid  = 0;
        dividend  = {$urandom, $urandom};
        divisor   = $urandom;
        out_ready = early_ready;
        lat = 1;
        while (!out_valid && lat < W + 10) begin
            chk("busy_in_ready", in_ready, 0);
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, eo ? 1 : W + 1);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("ovf", ovf, eo);
        if (!early_ready) begin
            repeat (hold) begin
                @(posedge clk); #1;
                chk("hold_valid", out_valid, 1);
                chk("hold_in_ready", in_ready, 0);
                chk("hold_quotient", quotient, eq);
                chk("hold_remainder", remainder, er);
                chk("hold_ovf", ovf, eo);
            end
            out_ready = 1;
        end
        @(posedge clk); #1;
        out_ready = 0;
        chk("retire_valid", out_valid, 0);
        chk("retire_in_ready", in_ready, 1);
        chk("retain_quotient", quotient, eq);
        chk("retain_remainder", remainder, er);
    endtask

    initial begin
        logic [31:0] a, b;
        rst_n = 0; in_valid = 0; out_ready = 0; dividend = '0; divisor = '0;
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_ovf", ovf, 0);
        @(posedge clk); #1; rst_n = 1;

        run(64'h0000_0001_0000_0000, 32'd2, 0, 0);
        run(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 0, 0);
        run(64'h1234_5678_9ABC_DEF0, 32'd0, 0, 0);
        run(64'h0000_0005_0000_0000, 32'd5, 0, 0);
        run(64'h0000_0004_FFFF_FFFF, 32'd5, 20, 0);
        run(64'h0000_0000_0000_0064, 32'd7, 0, 1);

        a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        for (int i = 0; i < 1000; i++) begin
            if (i > 0) begin
                a = $urandom;
                b = $urandom;
                if (b == 0) b = 1;
            end
            run(64'(a) * 64'(b) + ((i % 2) ? 64'(b - 1) : 64'd0), b, 0, 0);
        end

        dividend = 64'h0000_0003_0000_0000; divisor = 32'h8000_0001; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (10) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        @(posedge clk); #1; rst_n = 1;
        repeat (40) begin
            chk("abort_no_result", out_valid, 0);
            @(posedge clk); #1;
        end
        run(64'd100, 32'd7, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
